// File: rtl/hamming7_decoder.sv
// Hamming(7,4) single-error-correcting decoder, two-stage valid/ready pipeline.
// Define HAMMING7_DEC_STATS_EN to count delivered words that needed correction.
module hamming7_decoder (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  input  logic       in5,
  input  logic       in6,
  input  logic       in7,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       out4,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_syndrome,
  output logic       out_err,
  output logic [7:0] err_count
);

  logic       adv;
  logic [7:1] code_in;
  logic [2:0] syn_in;

  logic       s1_valid_q;
  logic [7:1] s1_code_q;
  logic [2:0] s1_syn_q;

  logic       out_valid_q;
  logic [3:0] data_q;
  logic [2:0] syn_q;
  logic       err_q;

  logic [7:0] flip_mask;
  logic [7:1] code_fixed;
  logic [3:0] data_d;

  // Both stages move together, so a stalled output freezes the whole pipe.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // Bit index equals codeword position so the syndrome selects the bit directly.
  assign code_in = {in7, in6, in5, in4, in3, in2, in1};

  assign syn_in[2] = code_in[4] ^ code_in[5] ^ code_in[6] ^ code_in[7];
  assign syn_in[1] = code_in[2] ^ code_in[3] ^ code_in[6] ^ code_in[7];
  assign syn_in[0] = code_in[1] ^ code_in[3] ^ code_in[5] ^ code_in[7];

  // Syndrome 0 sets only bit 0 of the mask, which falls outside the codeword.
  assign flip_mask  = 8'd1 << s1_syn_q;
  assign code_fixed = s1_code_q ^ flip_mask[7:1];
  assign data_d     = {code_fixed[3], code_fixed[5], code_fixed[6], code_fixed[7]};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      syn_q       <= '0;
      err_q       <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_code_q   <= code_in;
      s1_syn_q    <= syn_in;
      out_valid_q <= s1_valid_q;
      data_q      <= data_d;
      syn_q       <= s1_syn_q;
      err_q       <= (s1_syn_q != 3'd0);
    end
  end

  assign out_valid    = out_valid_q;
  assign out1         = data_q[3];
  assign out2         = data_q[2];
  assign out3         = data_q[1];
  assign out4         = data_q[0];
  assign out_syndrome = syn_q;
  assign out_err      = err_q;

`ifdef HAMMING7_DEC_STATS_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (out_valid_q && out_ready && err_q && (err_count_q != 8'hff)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_hamming7_decoder.sv
// Directed self-checking bench for hamming7_decoder; follows HAMMING7_DEC_STATS_EN
// to decide what err_count should read.
module tb_hamming7_decoder;

`ifdef HAMMING7_DEC_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in1, in2, in3, in4, in5, in6, in7;
  logic       out1, out2, out3, out4;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_syndrome;
  logic       out_err;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  hamming7_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .in4         (in4),
    .in5         (in5),
    .in6         (in6),
    .in7         (in7),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out4        (out4),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_syndrome(out_syndrome),
    .out_err     (out_err),
    .err_count   (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cw is written c1..c7, MSB first.
  task automatic set_word(input logic [6:0] cw);
    {in1, in2, in3, in4, in5, in6, in7} = cw;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; set_word(7'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if ({out1, out2, out3, out4} !== 4'b0000) begin errors++;
      $display("FAIL reset_data got=%b want=0000", {out1, out2, out3, out4}); end
    checks++; if (out_syndrome !== 3'd0) begin errors++;
      $display("FAIL reset_syndrome got=%0d want=0", out_syndrome); end
    checks++; if (out_err !== 1'b0) begin errors++;
      $display("FAIL reset_err got=%b want=0", out_err); end
    checks++; if (err_count !== 8'd0) begin errors++;
      $display("FAIL reset_err_count got=%0d want=0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_single(input string name, input logic [6:0] cw,
                             input logic [3:0] exp_d, input logic [2:0] exp_s,
                             input logic exp_e);
    @(posedge clock); #1;
    set_word(cw); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; set_word(7'd0);
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL %s_early_valid got=%b want=0", name, out_valid); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL %s_valid got=%b want=1", name, out_valid); end
    checks++; if ({out1, out2, out3, out4} !== exp_d) begin errors++;
      $display("FAIL %s_data got=%b want=%b", name, {out1, out2, out3, out4}, exp_d); end
    checks++; if (out_syndrome !== exp_s) begin errors++;
      $display("FAIL %s_syndrome got=%0d want=%0d", name, out_syndrome, exp_s); end
    checks++; if (out_err !== exp_e) begin errors++;
      $display("FAIL %s_err got=%b want=%b", name, out_err, exp_e); end
    if (Stats && exp_e) exp_cnt++;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL %s_drain got=%b want=0", name, out_valid); end
    checks++; if (err_count !== 8'(exp_cnt)) begin errors++;
      $display("FAIL %s_err_count got=%0d want=%0d", name, err_count, exp_cnt); end
  endtask

  task automatic test_backpressure;
    logic [6:0] cw[4];
    logic [3:0] dd[4];
    logic [2:0] ss[4];
    int  idx = 0;
    int  got = 0;
    int  stall = 0;
    bit  seen = 1'b0;
    bit  acc;
    cw = '{7'b1101001, 7'b0101010, 7'b1001110, 7'b1110000};
    dd = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ss = '{3'd0, 3'd0, 3'd6, 3'd0};
    @(posedge clock); #1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid = (idx < 4);
      set_word((idx < 4) ? cw[idx] : 7'd0);
      if (out_valid && !seen) seen = 1'b1;
      out_ready = !(seen && stall < 3);
      @(negedge clock);
      if (!out_ready) begin
        stall++;
        checks++; if (in_ready !== 1'b0) begin errors++;
          $display("FAIL bp_stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++;
          $display("FAIL bp_stall_valid cyc=%0d got=%b want=1", cyc, out_valid); end
        checks++; if ({out1, out2, out3, out4} !== dd[0] || out_syndrome !== ss[0]) begin
          errors++;
          $display("FAIL bp_stall_hold cyc=%0d got=%b/%0d want=%b/%0d", cyc,
                   {out1, out2, out3, out4}, out_syndrome, dd[0], ss[0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++; if ({out1, out2, out3, out4} !== dd[got]) begin errors++;
          $display("FAIL bp_word%0d_data got=%b want=%b", got, {out1, out2, out3, out4},
                   dd[got]); end
        checks++; if (out_syndrome !== ss[got] || out_err !== (ss[got] != 3'd0)) begin
          errors++;
          $display("FAIL bp_word%0d_syndrome got=%0d/%b want=%0d", got, out_syndrome,
                   out_err, ss[got]);
        end
        if (Stats && ss[got] != 3'd0) exp_cnt++;
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++; if (got != 4) begin errors++;
      $display("FAIL bp_delivered got=%0d want=4", got); end
    checks++; if (stall != 3) begin errors++;
      $display("FAIL bp_stall_cycles got=%0d want=3", stall); end
    checks++; if (err_count !== 8'(exp_cnt)) begin errors++;
      $display("FAIL bp_err_count got=%0d want=%0d", err_count, exp_cnt); end
  endtask

  task automatic test_mid_reset;
    int seen_valid = 0;
    @(posedge clock); #1;
    out_ready = 1'b1; in_valid = 1'b1; set_word(7'b0110111);
    @(posedge clock); #1;
    out_ready = 1'b0; set_word(7'b0110010);
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b0; set_word(7'd0);
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL mr_inflight_valid got=%b want=1", out_valid); end
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL mr_cleared_valid got=%b want=0", out_valid); end
    checks++; if (err_count !== 8'd0) begin errors++;
      $display("FAIL mr_err_count got=%0d want=0", err_count); end
    @(posedge clock); #1;
    reset = 1'b0; out_ready = 1'b1;
    exp_cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (out_valid) seen_valid++;
    end
    checks++; if (seen_valid != 0) begin errors++;
      $display("FAIL mr_ghost_words got=%0d want=0", seen_valid); end
    checks++; if (err_count !== 8'd0) begin errors++;
      $display("FAIL mr_err_count_after got=%0d want=0", err_count); end
  endtask

  task automatic test_back_to_back;
    int n = Stats ? 300 : 12;
    int sent = 0;
    int delivered = 0;
    int bad = 0;
    int first = -1;
    int last = -1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; out_ready = 1'b1; set_word(7'b0110111);
    exp_cnt = 0;
    for (int cyc = 0; cyc < n + 10; cyc++) begin
      in_valid = (sent < n);
      @(negedge clock);
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        delivered++;
        if ({out1, out2, out3, out4} !== 4'b1011 || out_syndrome !== 3'd5 || out_err !== 1'b1)
          bad++;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    checks++; if (delivered != n) begin errors++;
      $display("FAIL b2b_delivered got=%0d want=%0d", delivered, n); end
    checks++; if (last - first + 1 != delivered) begin errors++;
      $display("FAIL b2b_bubbles span=%0d words=%0d", last - first + 1, delivered); end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL b2b_word_content got=%0d bad words want=0", bad); end
    checks++; if (err_count !== (Stats ? 8'd255 : 8'd0)) begin errors++;
      $display("FAIL b2b_err_count got=%0d want=%0d", err_count, Stats ? 255 : 0); end
  endtask

  initial begin
    test_reset();
    test_single("clean",      7'b0110011, 4'b1011, 3'd0, 1'b0);
    test_single("err_c5",     7'b0110111, 4'b1011, 3'd5, 1'b1);
    test_single("err_c1",     7'b1110011, 4'b1011, 3'd1, 1'b1);
    test_single("err_c7",     7'b0110010, 4'b1011, 3'd7, 1'b1);
    test_single("err_c3",     7'b0100011, 4'b1011, 3'd3, 1'b1);
    test_single("zeros",      7'b0000000, 4'b0000, 3'd0, 1'b0);
    test_single("ones",       7'b1111111, 4'b1111, 3'd0, 1'b0);
    test_single("double_c12", 7'b1010011, 4'b0011, 3'd3, 1'b1);
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming7_decoder.md
HAMMING7_DECODER -- requirements
Module: hamming7_decoder

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have port: in_valid  input  1  codeword on in1..in7 is valid this cycle.
REQ-004 SHALL have port: in_ready  output  1  block accepts codeword this cycle.
REQ-005 SHALL have ports: in1..in7  input  1 each  received codeword bits c1..c7; parity at c1, c2, c4; data at c3, c5, c6, c7.
REQ-006 SHALL have ports: out1..out4  output  1 each  corrected data d1..d4 = corrected c3, c5, c6, c7.
REQ-007 SHALL have port: out_valid  output  1  output word valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts output word.
REQ-009 SHALL have port: out_syndrome  output  3  syndrome of the word presented on out1..out4.
REQ-010 SHALL have port: out_err  output  1  high when out_syndrome is non-zero.
REQ-011 SHALL have port: err_count  output  8  count of corrected words delivered (see Configuration).

Function
REQ-012 SHALL compute syndrome s[2] = c4^c5^c6^c7, s[1] = c2^c3^c6^c7, s[0] = c1^c3^c5^c7; s = bit position (1..7) of a single-bit error, 0 = no error.
REQ-013 SHALL invert codeword bit c[s] when s != 0, then extract d1..d4; errors in parity positions 1, 2, 4 leave data unchanged.
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers codeword and syndrome; stage 2 registers corrected data, syndrome and error flag.
REQ-015 SHALL have latency of exactly 2 clock edges from input handshake to out_valid, with no stalls.
REQ-016 SHALL use one advance enable: adv = ~out_valid | out_ready; both stages load only when adv = 1.
REQ-017 SHALL drive in_ready = adv combinationally; input handshake = in_valid & in_ready.
REQ-018 SHALL set stage-1 valid to in_valid on each advance, and stage-2 valid (out_valid) to stage-1 valid on each advance.
REQ-019 SHALL hold out1..out4, out_syndrome and out_err stable while out_valid & ~out_ready.
REQ-020 SHALL sustain one word per cycle when out_ready is held high, with no bubbles.
REQ-021 SHALL not detect double-bit errors; they are miscorrected as single-bit errors (SEC only).
REQ-022 SHALL leave data outputs undefined-but-stable when out_valid = 0; they are don't-care for checking.

Reset
REQ-023 SHALL, on reset = 1, clear both stage valids and zero all data/syndrome registers: out_valid = 0, out1..out4 = 0, out_syndrome = 0, out_err = 0, err_count = 0, on the next edge.
REQ-024 SHALL discard in-flight words when reset is asserted mid-stream; no word accepted before or during reset appears afterwards.
REQ-025 SHALL give reset priority over advance and counter update in the same cycle.

Configuration
REQ-026 SHALL support macro HAMMING7_DEC_STATS_EN; when defined, err_count increments by 1 on each output handshake (out_valid & out_ready) with out_err = 1.
REQ-027 SHALL, when HAMMING7_DEC_STATS_EN is defined, saturate err_count at 255 with no wrap.
REQ-028 SHALL, when HAMMING7_DEC_STATS_EN is not defined, tie err_count to constant 0 and include no counter register.

Verification
REQ-029 SHALL cover clean word: reset, then c1..c7 = 0110011 with in_valid = 1, out_ready = 1 -> two edges later out_valid = 1, d1..d4 = 1011, syndrome 0, out_err = 0.
REQ-030 SHALL cover data-bit error: c1..c7 = 0110111 (c5 flipped) -> d1..d4 = 1011, syndrome 5, out_err = 1; err_count = 1 with STATS_EN defined, 0 without.
REQ-031 SHALL cover parity-bit error: c1..c7 = 1110011 (c1 flipped) -> d1..d4 = 1011, syndrome 1, out_err = 1.
REQ-032 SHALL cover backpressure: stream of 4 words with out_ready = 0 for 3 cycles after first output -> in_ready = 0 during stall, output held stable, all 4 words delivered in order once out_ready = 1.
REQ-033 SHALL cover reset mid-stream: assert reset while 2 words are in flight -> out_valid = 0 next cycle, neither word ever emitted, err_count = 0.
REQ-034 SHALL cover saturation (STATS_EN defined): 300 back-to-back single-error words -> err_count stops at 255.
